sid_voice_sched: RTL

Time-multiplexing scheduler that shares one voice datapath (accumulator, envelope and waveform engine with per-voice context storage) among the three SID voices. On every phase-2 tick it issues three voice slots in order 0, 1, 2 over a valid/ready handshake. It routes each voice's ring-modulation and hard-sync source to the engine using the fixed SID topology, captures each voice's 12-bit output, and produces the registered three-voice mix for the output filter/DAC stage.

---
 rtl/sid_voice_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sid_voice_sched.sv
// Three-voice time-multiplexing scheduler for a shared SID voice engine.
// Issues slots 0,1,2 per tick, routes ring/sync sources, captures outputs, builds the mix.
module sid_voice_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [2:0]  voice_mute,
    input  logic        clr_overrun,
    output logic        eng_valid,
    output logic [1:0]  eng_voice,
    output logic        eng_ring_in,
    output logic        eng_sync_in,
    input  logic        eng_ready,
    input  logic [11:0] eng_out,
    input  logic        eng_ring_out,
    input  logic        eng_sync_out,
    output logic [11:0] v_out0,
    output logic [11:0] v_out1,
    output logic [11:0] v_out2,
    output logic [13:0] mix,
    output logic        mix_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MIX} state_t;

    state_t      state_q, state_d;
    logic [1:0]  slot_q, slot_d;
    logic [2:0]  ring_snap_q, ring_snap_d;
    logic [2:0]  sync_snap_q, sync_snap_d;
    logic [2:0]  cap_ring_q, cap_ring_d;
    logic [2:0]  cap_sync_q, cap_sync_d;
    logic [11:0] vout_q [3];
    logic [11:0] vout_d [3];
    logic [13:0] mix_q, mix_d;
    logic        overrun_q, overrun_d;
    logic        xfer;
    logic [13:0] mix_sum;

    assign xfer = (state_q == S_RUN) && eng_ready;

    // Per-voice capture: each voice only updates when its own slot transfers.
    for (genvar gi = 0; gi < 3; gi++) begin : g_voice
        always_comb begin
            vout_d[gi]     = vout_q[gi];
            cap_ring_d[gi] = cap_ring_q[gi];
            cap_sync_d[gi] = cap_sync_q[gi];
            if (xfer && (slot_q == gi)) begin
                vout_d[gi]     = eng_out;
                cap_ring_d[gi] = eng_ring_out;
                cap_sync_d[gi] = eng_sync_out;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vout_q[gi]     <= 12'd0;
                cap_ring_q[gi] <= 1'b0;
                cap_sync_q[gi] <= 1'b0;
            end else begin
                vout_q[gi]     <= vout_d[gi];
                cap_ring_q[gi] <= cap_ring_d[gi];
                cap_sync_q[gi] <= cap_sync_d[gi];
            end
        end
    end

    // Slot 2 is still on the bus when the mix is formed, so use eng_out directly.
    assign mix_sum = (voice_mute[0] ? 14'd0 : {2'b00, vout_q[0]})
                   + (voice_mute[1] ? 14'd0 : {2'b00, vout_q[1]})
                   + (voice_mute[2] ? 14'd0 : {2'b00, eng_out});

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        ring_snap_d = ring_snap_q;
        sync_snap_d = sync_snap_q;
        mix_d       = mix_q;
        overrun_d   = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    ring_snap_d = cap_ring_q;
                    sync_snap_d = cap_sync_q;
                    slot_d      = 2'd0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (eng_ready) begin
                    if (slot_q == 2'd2) begin
                        slot_d  = 2'd0;
                        mix_d   = mix_sum;
                        state_d = S_MIX;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            S_MIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clr_overrun) overrun_d = 1'b0;
        if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            slot_q      <= 2'd0;
            ring_snap_q <= 3'd0;
            sync_snap_q <= 3'd0;
            mix_q       <= 14'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            ring_snap_q <= ring_snap_d;
            sync_snap_q <= sync_snap_d;
            mix_q       <= mix_d;
            overrun_q   <= overrun_d;
        end
    end

    // Fixed SID topology: voice 0 <- 2, voice 1 <- 0, voice 2 <- 1.
    always_comb begin
        eng_ring_in = 1'b0;
        eng_sync_in = 1'b0;
        case (slot_q)
            2'd0: begin eng_ring_in = ring_snap_q[2]; eng_sync_in = sync_snap_q[2]; end
            2'd1: begin eng_ring_in = ring_snap_q[0]; eng_sync_in = sync_snap_q[0]; end
            2'd2: begin eng_ring_in = ring_snap_q[1]; eng_sync_in = sync_snap_q[1]; end
            default: begin eng_ring_in = 1'b0; eng_sync_in = 1'b0; end
        endcase
    end

    assign eng_valid = (state_q == S_RUN);
    assign eng_voice = slot_q;
    assign v_out0    = vout_q[0];
    assign v_out1    = vout_q[1];
    assign v_out2    = vout_q[2];
    assign mix       = mix_q;
    assign mix_valid = (state_q == S_MIX);
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule
